// File: rtl/kule_spi_pkg.sv
// Shared definitions for the MCU<->FPGA SPI link: status frame layout,
// transmitter state encoding and the CRC-8 helper.
// Build option: SPI_STATUS_CRC_EN appends a CRC-8 byte to the status frame.
package kule_spi_pkg;

  localparam logic [3:0] STATUS_MAGIC    = 4'hA;
  localparam logic [7:0] STATUS_CRC_POLY = 8'h07;

`ifdef SPI_STATUS_CRC_EN
  localparam int STATUS_BYTES = 5;
`else
  localparam int STATUS_BYTES = 4;
`endif

  // Byte positions within the status frame, B0 is sent first.
  localparam int BYTE_FLAGS    = 0;
  localparam int BYTE_QCOUNT   = 1;
  localparam int BYTE_FRAME_HI = 2;
  localparam int BYTE_FRAME_LO = 3;
`ifdef SPI_STATUS_CRC_EN
  localparam int BYTE_CRC      = 4;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} spi_tx_state_t;

  // One byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ STATUS_CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_status_tx_if.sv
// SPI pin bundle between the MCU (master) and the status transmitter (slave).
interface spi_status_tx_if;
  logic spi_cs;
  logic spi_clk;
  logic spi_miso;
  logic spi_miso_oe;

  modport slave  (input spi_cs, input spi_clk, output spi_miso, output spi_miso_oe);
  modport master (output spi_cs, output spi_clk, input spi_miso, input spi_miso_oe);
endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin followed by an edge
// detector. RESET_VAL is the idle level of the pin so that reset release
// does not fabricate an edge.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus the edge-detect history register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_status_tx.sv
// SPI slave MISO transmitter: while CS is low, shifts a status snapshot
// (framebuffer/queue flags, queue count, vsync frame counter) to the MCU,
// MSB first, SPI mode 0, then fills with 0xFF.
// Build option: SPI_STATUS_CRC_EN adds a fifth CRC-8 byte over B0..B3.
module spi_status_tx
  import kule_spi_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int QUEUE_COUNT_W = 8,
  parameter int FRAME_CNT_W   = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  spi_status_tx_if.slave           spi,
  input  logic                     vsync,
  input  logic                     fb_resetting,
  input  logic                     queue_empty,
  input  logic                     queue_full,
  input  logic [QUEUE_COUNT_W-1:0] queue_count,
  output logic [FRAME_CNT_W-1:0]   frame_count,
  output logic                     tx_active
);

  localparam int          SHIFT_W   = 8 * STATUS_BYTES;
  localparam logic [2:0]  LAST_BYTE = 3'(STATUS_BYTES - 1);

  spi_tx_state_t          state;
  logic [SHIFT_W-1:0]     shreg;
  logic [SHIFT_W-1:0]     load_vec;
  logic [7:0]             snap_b [STATUS_BYTES];
  logic [2:0]             bit_cnt;
  logic [2:0]             byte_idx;
  logic                   miso_q;
  logic                   oe_q;
  logic                   cs_rise;
  logic                   cs_fall;
  logic                   sck_fall;
  logic                   sck_fall_p1;
  logic                   sck_rise_unused;
  logic                   vsync_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
`ifdef SPI_STATUS_CRC_EN
  logic [7:0]             crc;
`endif

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (spi.spi_cs),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (spi.spi_clk),
    .rise    (sck_rise_unused),
    .fall    (sck_fall)
  );

  // Delay the SCK event one cycle so every bit lands at the same latency
  // after its SCK fall as bit 7 does after CS fall (which pays for LOAD).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sck_fall_p1 <= 1'b0;
    else          sck_fall_p1 <= sck_fall;
  end

  // Vsync rising-edge frame counter, wraps naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vsync_q <= vsync;
      if (vsync && !vsync_q) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // Snapshot bytes taken from the live inputs; frame_cnt_q still holds the
  // pre-increment value in a cycle where a vsync edge is being counted.
  always_comb begin
    snap_b[BYTE_FLAGS]    = {STATUS_MAGIC, fb_resetting, queue_full, queue_empty, frame_cnt_q[0]};
    snap_b[BYTE_QCOUNT]   = queue_count[7:0];
    snap_b[BYTE_FRAME_HI] = frame_cnt_q[15:8];
    snap_b[BYTE_FRAME_LO] = frame_cnt_q[7:0];
`ifdef SPI_STATUS_CRC_EN
    crc = 8'h00;
    for (int i = 0; i < BYTE_CRC; i++) begin
      crc = crc8_byte(crc, snap_b[i]);
    end
    snap_b[BYTE_CRC] = crc;
`endif
  end

  // Pack the frame with B0 in the MSBs so one long shift register serves all bytes.
  always_comb begin
    load_vec = '0;
    for (int i = 0; i < STATUS_BYTES; i++) begin
      load_vec[8*(STATUS_BYTES-1-i) +: 8] = snap_b[i];
    end
  end

  // Transmit FSM; CS release wins over any pending SCK event.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      miso_q   <= 1'b1;
      oe_q     <= 1'b0;
    end else if (cs_rise) begin
      state  <= IDLE;
      miso_q <= 1'b1;
      oe_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          miso_q <= 1'b1;
          oe_q   <= 1'b0;
          if (cs_fall) state <= LOAD;
        end
        LOAD: begin
          shreg    <= load_vec;
          miso_q   <= load_vec[SHIFT_W-1];
          oe_q     <= 1'b1;
          bit_cnt  <= 3'd7;
          byte_idx <= '0;
          state    <= SHIFT;
        end
        SHIFT: begin
          if (sck_fall_p1) begin
            shreg  <= {shreg[SHIFT_W-2:0], 1'b1};
            miso_q <= shreg[SHIFT_W-2];
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
            end else if (byte_idx == LAST_BYTE) begin
              miso_q <= 1'b1;
              state  <= DONE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              bit_cnt  <= 3'd7;
            end
          end
        end
        DONE: begin
          miso_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;
  assign frame_count     = frame_cnt_q;
  assign tx_active       = (state != IDLE);

endmodule

// File: tb/tb_spi_status_tx.sv
// Directed bench for spi_status_tx: expected status bytes are queued when a
// transaction is set up and popped as the bits are shifted back on MISO.
module tb_spi_status_tx;

  localparam int SS = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        vsync = 1'b0;
  logic        fb_resetting = 1'b0;
  logic        queue_empty = 1'b0;
  logic        queue_full = 1'b0;
  logic [7:0]  queue_count = 8'h00;
  logic [15:0] frame_count;
  logic        tx_active;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] fc_model = 16'h0000;
  logic [7:0]  exp_q [$];

  always #5 clock = ~clock;

  spi_status_tx_if spi_bus ();

  spi_status_tx #(.SYNC_STAGES(SS), .QUEUE_COUNT_W(8), .FRAME_CNT_W(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .spi          (spi_bus),
    .vsync        (vsync),
    .fb_resetting (fb_resetting),
    .queue_empty  (queue_empty),
    .queue_full   (queue_full),
    .queue_count  (queue_count),
    .frame_count  (frame_count),
    .tx_active    (tx_active)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(1);
    fc_model = fc_model + 16'd1;
  endtask

  // Bit-serial CRC-8 (poly x^8+x^2+x+1) over a 32-bit message, MSB first.
  function automatic logic [7:0] crc_model(input logic [31:0] msg);
    logic [7:0] r;
    logic       fbk;
    r = 8'h00;
    for (int k = 31; k >= 0; k--) begin
      fbk = r[7] ^ msg[k];
      r   = {r[6:0], 1'b0} ^ (fbk ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Queue the first n bytes the MCU should see for the current inputs.
  task automatic push_snapshot(input int n);
    logic [7:0] seq [8];
    seq[0] = {4'hA, fb_resetting, queue_full, queue_empty, fc_model[0]};
    seq[1] = queue_count;
    seq[2] = fc_model[15:8];
    seq[3] = fc_model[7:0];
    for (int k = 4; k < 8; k++) seq[k] = 8'hFF;
`ifdef SPI_STATUS_CRC_EN
    seq[4] = crc_model({seq[0], seq[1], seq[2], seq[3]});
`endif
    for (int k = 0; k < n; k++) exp_q.push_back(seq[k]);
  endtask

  // One MCU transaction of nbits SCK cycles, MISO sampled just before each
  // SCK rise. toggle: disturb inputs mid-frame; vs_at_load: vsync edge in
  // the LOAD cycle; rst_at >= 0: assert reset before sampling that bit.
  task automatic xfer(input int nbits, input bit toggle, input bit vs_at_load, input int rst_at);
    logic [7:0] cur;
    logic [7:0] e;
    int         nfull;
    nfull = ((rst_at >= 0) ? rst_at : nbits) / 8;
    check("sb_depth", exp_q.size(), nfull);
    spi_bus.spi_cs = 1'b0;
    if (vs_at_load) begin
      tick(3);
      vsync = 1'b1;
      tick(1);
      vsync = 1'b0;
      fc_model = fc_model + 16'd1;
      tick(2);
    end else begin
      tick(6);
    end
    cur = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_oe", spi_bus.spi_miso_oe, 1'b0);
        check("rst_miso", spi_bus.spi_miso, 1'b1);
        check("rst_frame", frame_count, 16'h0000);
        check("rst_active", tx_active, 1'b0);
        spi_bus.spi_cs = 1'b1;
        tick(2);
        reset_n = 1'b1;
        fc_model = 16'h0000;
        tick(2);
        return;
      end
      if (i == 0) begin
        check("oe_active", spi_bus.spi_miso_oe, 1'b1);
        check("tx_active", tx_active, 1'b1);
      end
      cur = {cur[6:0], spi_bus.spi_miso};
      if (i % 8 == 7) begin
        e = exp_q.pop_front();
        check($sformatf("byte%0d", i / 8), cur, e);
      end
      spi_bus.spi_clk = 1'b1;
      if (toggle && i == 5) begin
        vsync = 1'b1;
        tick(1);
        vsync = 1'b0;
        fc_model = fc_model + 16'd1;
        fb_resetting = ~fb_resetting;
        queue_full   = ~queue_full;
        queue_empty  = ~queue_empty;
        queue_count  = queue_count + 8'h11;
        tick(3);
      end else begin
        tick(4);
      end
      spi_bus.spi_clk = 1'b0;
      tick(4);
    end
    spi_bus.spi_cs = 1'b1;
    tick(SS + 2);
    check("oe_release", spi_bus.spi_miso_oe, 1'b0);
    check("tx_idle", tx_active, 1'b0);
    tick(4);
  endtask

  initial begin
    spi_bus.spi_cs  = 1'b1;
    spi_bus.spi_clk = 1'b0;
    reset_n = 1'b0;
    tick(3);
    check("reset_miso", spi_bus.spi_miso, 1'b1);
    check("reset_oe", spi_bus.spi_miso_oe, 1'b0);
    check("reset_frame", frame_count, 16'h0000);
    check("reset_active", tx_active, 1'b0);
    reset_n = 1'b1;
    tick(2);

    // Basic read: expect A9 05 00 03.
    fb_resetting = 1'b1; queue_count = 8'd5; queue_empty = 1'b0; queue_full = 1'b0;
    repeat (3) vsync_pulse();
    check("frame_after_3", frame_count, fc_model);
    push_snapshot(4);
    xfer(32, 1'b0, 1'b0, -1);

    // Overrun: 48 clocks, tail is CRC (if built) then 0xFF fill.
    fb_resetting = 1'b0; queue_count = 8'hC3; queue_empty = 1'b1; queue_full = 1'b0;
    repeat (2) vsync_pulse();
    push_snapshot(6);
    xfer(48, 1'b0, 1'b0, -1);

    // Abort after 11 bits, then a fresh transaction restarts at B0.
    fb_resetting = 1'b1; queue_count = 8'h7F; queue_empty = 1'b0; queue_full = 1'b1;
    push_snapshot(1);
    xfer(11, 1'b0, 1'b0, -1);
    vsync_pulse();
    queue_count = 8'h42;
    push_snapshot(4);
    xfer(32, 1'b0, 1'b0, -1);

    // Inputs disturbed mid-frame must not alter the bytes.
    push_snapshot(4);
    xfer(32, 1'b1, 1'b0, -1);
    check("frame_after_toggle", frame_count, fc_model);

    // Vsync edge in the LOAD cycle: snapshot carries the old count.
    push_snapshot(4);
    xfer(32, 1'b0, 1'b1, -1);
    check("frame_after_collision", frame_count, fc_model);

    // Reset at bit 20, then a new snapshot with a cleared counter.
    push_snapshot(2);
    xfer(32, 1'b0, 1'b0, 20);
    check("frame_after_reset", frame_count, fc_model);
    push_snapshot(4);
    xfer(32, 1'b0, 1'b0, -1);

    // Wrap: 65537 pulses from zero lands on 1.
    for (int p = 0; p < 65537; p++) vsync_pulse();
    check("frame_wrap", frame_count, 16'h0001);
    push_snapshot(4);
    xfer(32, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
